queue_drain_framer: RTL and testbench

- Consumer end of the 8-bit queue controller's enq/deq interface.
- Pops words from the queue (data/empty/deq), groups them into frames of a programmable burst length, and presents them on a valid/ready stream with an end-of-frame flag.
- A partially filled frame is closed by a timeout that emits a pad word carrying the flag.
- Sits between the queue controller and the downstream link/packetiser.

---
 rtl/queue_drain_pkg.sv | 26 ++
 rtl/skid_buffer2.sv | 55 +++++
 rtl/queue_drain_framer.sv | 129 ++++++++++++
 tb/tb_queue_drain_framer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/queue_drain_pkg.sv
// Shared types and constants for the queue drain framer.
// Frame length helper maps a burst_len of 0 to the maximum burst.
package queue_drain_pkg;

  localparam int MAX_BURST   = 16;
  localparam int FRAME_CNT_W = 16;
  localparam int WORD_W      = 8;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  typedef struct packed {
    logic              last;
    logic [WORD_W-1:0] data;
  } entry_t;

  function automatic logic [4:0] norm_len(
    input logic [3:0] bl
  );
    return (bl == 4'd0) ? 5'(MAX_BURST)
                        : {1'b0, bl};
  endfunction

endpackage

// File: rtl/skid_buffer2.sv
// Two-entry first-word-fall-through buffer.
// Entry 0 is always the head; a pop shifts entry 1 forward.
module skid_buffer2 #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [1:0]   count,
  output logic [W-1:0] head
);

  logic [W-1:0] e0_q, e1_q;
  logic [W-1:0] e0_n, e1_n;
  logic [1:0]   fill, cnt_n;
  logic         pop_ok, push_ok;

  // Next entries: shift on pop, then write into first free slot.
  always_comb begin
    e0_n    = e0_q;
    e1_n    = e1_q;
    pop_ok  = pop && (count != 2'd0);
    fill    = count - {1'b0, pop_ok};
    push_ok = push && (fill != 2'd2);
    if (pop_ok) begin
      e0_n = e1_q;
    end
    if (push_ok) begin
      if (fill == 2'd0) begin
        e0_n = din;
      end else begin
        e1_n = din;
      end
    end
    cnt_n = fill + {1'b0, push_ok};
  end

  // Storage and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e0_q  <= '0;
      e1_q  <= '0;
      count <= 2'd0;
    end else begin
      e0_q  <= e0_n;
      e1_q  <= e1_n;
      count <= cnt_n;
    end
  end

  assign head = e0_q;

endmodule

// File: rtl/queue_drain_framer.sv
// Pops queue words into burst-length frames on a valid/ready stream.
// An idle open frame is closed by a pad word carrying the last flag.
module queue_drain_framer
  import queue_drain_pkg::*;
#(
  parameter int                DATA_W = 8,
  parameter int                TO_W   = 8,
  parameter logic [DATA_W-1:0] PAD    = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [3:0]             burst_len,
  input  logic [TO_W-1:0]        timeout,
  input  logic                   q_empty,
  input  logic [DATA_W-1:0]      q_data,
  output logic                   q_deq,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_last,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  localparam int EW = DATA_W + 1;

  logic [1:0]      count;
  logic [EW-1:0]   head, push_word;
  logic            push, pop;
  logic            has_room, to_hit;
  logic            pad_push, data_last;
  state_e          state_q;
  logic [4:0]      len_q, beat_q;
  logic [4:0]      first_len;
  logic [TO_W-1:0] idle_q;
  logic [FRAME_CNT_W-1:0] frame_q;

  // Room is judged on the registered count so out_ready
  // never reaches q_deq combinationally.
  assign has_room  = (count != 2'd2);
  assign q_deq     = !rst && enable
                  && !q_empty && has_room;
  assign first_len = norm_len(burst_len);
  assign to_hit    = (state_q == ACTIVE)
                  && (timeout != '0)
                  && (idle_q >= timeout);
  assign pad_push  = to_hit && has_room && !q_deq;

  // Last tag for a data word pushed this cycle.
  always_comb begin
    data_last = 1'b0;
    if (state_q == IDLE) begin
      data_last = (first_len == 5'd1);
    end else begin
      data_last = ((beat_q + 5'd1) == len_q);
    end
  end

  assign push      = q_deq || pad_push;
  assign push_word = pad_push ? {1'b1, PAD}
                              : {data_last, q_data};

  skid_buffer2 #(
    .W (EW)
  ) u_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (push_word),
    .pop   (pop),
    .count (count),
    .head  (head)
  );

  assign out_valid = (count != 2'd0);
  assign pop       = out_valid && out_ready;
  assign out_last  = head[DATA_W];
  assign out_data  = head[DATA_W-1:0];

  // Framing FSM with beat and idle counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= 5'd0;
      beat_q  <= 5'd0;
      idle_q  <= '0;
    end else begin
      unique case (1'b1)
        q_deq: begin
          idle_q <= '0;
          if (state_q == IDLE) begin
            len_q <= first_len;
          end
          if (data_last) begin
            state_q <= IDLE;
            beat_q  <= 5'd0;
          end else begin
            state_q <= ACTIVE;
            beat_q  <= (state_q == IDLE)
                     ? 5'd1 : beat_q + 5'd1;
          end
        end
        pad_push: begin
          state_q <= IDLE;
          beat_q  <= 5'd0;
          idle_q  <= '0;
        end
        default: begin
          // Hold at the threshold while a pad waits for room.
          if (state_q == ACTIVE && idle_q < timeout) begin
            idle_q <= idle_q + TO_W'(1);
          end
        end
      endcase
    end
  end

  // Completed frames, counted on accepted last words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_q <= '0;
    end else if (pop && head[DATA_W] && frame_q != '1) begin
      frame_q <= frame_q + 1'b1;
    end
  end

  assign frame_cnt = frame_q;

endmodule

// File: tb/tb_queue_drain_framer.sv
// Scoreboard bench for queue_drain_framer.
// A frame-level model predicts pops and stream words.
module tb_queue_drain_framer;
  import queue_drain_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic [3:0]  burst_len = 4'd4;
  logic [7:0]  timeout = 8'd0;
  logic        q_empty = 1'b1;
  logic [7:0]  q_data = 8'h00;
  logic        q_deq;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic        out_last;
  logic [15:0] frame_cnt;

  queue_drain_framer dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .burst_len (burst_len),
    .timeout   (timeout),
    .q_empty   (q_empty),
    .q_data    (q_data),
    .q_deq     (q_deq),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0]  src_q[$];
  entry_t      exp_q[$];
  int          m_occ = 0;
  bit          m_open = 1'b0;
  int          m_n = 0;
  int          m_len = 0;
  int          m_idle = 0;
  logic [15:0] exp_frames = 16'd0;
  bit          d_deq, d_pad, d_acc;
  bit          prev_stall = 1'b0;
  logic [7:0]  prev_data;
  logic        prev_last;

  task automatic chk(string name,
                     logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic refresh_q();
    q_empty = (src_q.size() == 0);
    q_data  = q_empty ? 8'h00 : src_q[0];
  endtask

  task automatic put(logic [7:0] w);
    src_q.push_back(w);
    refresh_q();
  endtask

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model: decide at negedge, commit at posedge.
  always begin
    entry_t e;
    @(negedge clk);
    if (rst) begin
      d_deq = 0; d_pad = 0; d_acc = 0;
    end else begin
      d_deq = enable && src_q.size() != 0
           && m_occ < 2;
      d_pad = !d_deq && m_open && timeout != 0
           && m_idle >= int'(timeout) && m_occ < 2;
      d_acc = m_occ != 0 && out_ready;
      chk("q_deq", 32'(q_deq), 32'(d_deq));
      chk("out_valid", 32'(out_valid),
          32'(m_occ != 0));
    end
    @(posedge clk);
    if (!rst) begin
      if (d_deq) begin
        if (!m_open) begin
          m_open = 1;
          m_len  = (burst_len == 0) ? 16
                                    : int'(burst_len);
          m_n    = 0;
        end
        m_n++;
        e.data = src_q.pop_front();
        e.last = (m_n == m_len);
        if (e.last) m_open = 0;
        m_idle = 0;
        exp_q.push_back(e);
        m_occ++;
      end else if (d_pad) begin
        e.data = 8'h00;
        e.last = 1'b1;
        exp_q.push_back(e);
        m_open = 0;
        m_idle = 0;
        m_occ++;
      end else if (m_open) begin
        m_idle++;
      end
      if (d_acc) m_occ--;
    end
    #1 refresh_q();
  end

  // Monitor: compare every accepted word with the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      chk("frame_cnt", 32'(frame_cnt), 32'(exp_frames));
      if (prev_stall) begin
        chk("stall_data", 32'(out_data), 32'(prev_data));
        chk("stall_last", 32'(out_last), 32'(prev_last));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 32'(out_data), 32'hFFFF);
        end else begin
          entry_t e;
          e = exp_q.pop_front();
          chk("out_data", 32'(out_data), 32'(e.data));
          chk("out_last", 32'(out_last), 32'(e.last));
          if (e.last && exp_frames != 16'hFFFF)
            exp_frames++;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  task automatic wait_idle(int maxc);
    int n = 0;
    enable    = 1'b1;
    out_ready = 1'b1;
    while (!(src_q.size() == 0 && exp_q.size() == 0
             && !m_open && m_occ == 0) && n < maxc) begin
      cyc(1);
      n++;
    end
    chk("drain_timeout", 32'(n < maxc), 32'd1);
  endtask

  initial begin
    refresh_q();
    #1 rst = 1'b1;
    #11;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_q_deq", 32'(q_deq), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    cyc(1);
    rst = 1'b0;

    // Two full frames of four.
    burst_len = 4'd4; timeout = 8'd0; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) put(8'(8'h10 + i));
    cyc(1);
    enable = 1'b1;
    wait_idle(100);
    chk("t1_frames", 32'(frame_cnt), 32'd2);

    // Partial frame closed by pad.
    enable = 1'b0; timeout = 8'd5;
    for (int i = 0; i < 3; i++) put(8'(8'hA0 + i));
    cyc(1);
    wait_idle(100);
    chk("t2_frames", 32'(frame_cnt), 32'd3);

    // Downstream stall with five queued words.
    enable = 1'b0; timeout = 8'd0; burst_len = 4'd5;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) put(8'(8'h30 + i));
    cyc(1);
    enable = 1'b1;
    cyc(6);
    chk("t3_head", 32'(out_data), 32'h30);
    chk("t3_left", 32'(src_q.size()), 32'd3);
    wait_idle(100);
    chk("t3_frames", 32'(frame_cnt), 32'd4);

    // Max burst, then a mid-frame burst_len change.
    enable = 1'b0; burst_len = 4'd0;
    for (int i = 0; i < 20; i++) put(8'(8'h40 + i));
    cyc(1);
    enable = 1'b1;
    cyc(5);
    burst_len = 4'd2;
    wait_idle(100);
    chk("t4_frames", 32'(frame_cnt), 32'd7);

    // Data arrives on the cycle the timeout would fire.
    burst_len = 4'd4; timeout = 8'd3;
    put(8'h60);
    cyc(4);
    put(8'h61);
    wait_idle(100);
    chk("t5_frames", 32'(frame_cnt), 32'd8);

    // Asynchronous reset with two words buffered.
    burst_len = 4'd3; timeout = 8'd0; out_ready = 1'b0;
    for (int i = 0; i < 4; i++) put(8'(8'h70 + i));
    cyc(4);
    #1 rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_q_deq", 32'(q_deq), 32'd0);
    chk("arst_frame_cnt", 32'(frame_cnt), 32'd0);
    exp_q.delete();
    m_occ = 0; m_open = 0; m_idle = 0; m_n = 0;
    exp_frames = 16'd0; prev_stall = 0;
    #1 rst = 1'b0;
    cyc(1);
    out_ready = 1'b1;
    cyc(4);
    put(8'h7F);
    wait_idle(100);
    chk("t6_frames", 32'(frame_cnt), 32'd1);

    // Randomized traffic, timeout fixed per segment.
    for (int s = 0; s < 4; s++) begin
      case (s)
        0: timeout = 8'd1;
        1: timeout = 8'd2;
        2: timeout = 8'd5;
        default: timeout = 8'd9;
      endcase
      for (int c = 0; c < 250; c++) begin
        if (src_q.size() < 6 && $urandom_range(0, 2) == 0)
          put(8'($urandom));
        out_ready = ($urandom_range(0, 3) != 0);
        enable    = ($urandom_range(0, 7) != 0);
        burst_len = 4'($urandom_range(0, 15));
        cyc(1);
      end
      wait_idle(300);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
